mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares the single unified instruction/data memory of the multi-cycle MIPS core between two requesters: the CPU and a DMA/program-loader port.
- Sequences every memory access through a fixed issue/wait/complete protocol.
- Gives the CPU priority, with a starvation guard for the DMA.
- Sits between the core's memory interface (cpu_ready feeds the controller's stall/PC-enable gating) and the memory macro.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- MEM_LAT, 1, cycles from the memory issue cycle to mem_rdata valid; legal values are ≥1.
- STARVE_LIMIT, 4, maximum consecutive CPU grants while dma_req is pending.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- cpu_req  input  1  CPU access request; level, held until cpu_ready.
- cpu_we  input  1  CPU write enable; valid with cpu_req.
- cpu_addr  input  AW  CPU byte address.
- cpu_wdata  input  DW  CPU write data.
- cpu_rdata  output  DW  CPU read data, registered.
- cpu_ready  output  1  one-cycle completion pulse to the CPU.
- dma_req  input  1  DMA access request; level, held until dma_ack.
- dma_we  input  1  DMA write enable.
- dma_addr  input  AW  DMA address.
- dma_wdata  input  DW  DMA write data.
- dma_rdata  output  DW  DMA read data, registered.
- dma_ack  output  1  one-cycle completion pulse to the DMA.
- mem_en  output  1  memory access strobe.
- mem_we  output  1  memory write enable.
- mem_addr  output  AW  memory address.
- mem_wdata  output  DW  memory write data.
- mem_rdata  input  DW  memory read data, valid MEM_LAT cycles after the mem_en cycle.
- busy  output  1  high whenever the state is not IDLE.
- owner  output  1  current/last winner: 0 = CPU, 1 = DMA.

Behaviour:
- Reset (async, reset=0), all registers cleared:
  - state=IDLE.
  - mem_en, mem_we, cpu_ready, dma_ack, busy, owner = 0.
  - mem_addr, mem_wdata, cpu_rdata, dma_rdata = 0.
  - Wait counter and starve counter = 0.
- Reset mid-access aborts the transaction: no ack is produced and the outputs return to reset values immediately.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If any req is high at the clock edge, select a winner.
  - Latch the winner's we/addr/wdata into command registers, set owner, go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE:
  - mem_en=1 for exactly this cycle; mem_we/mem_addr/mem_wdata driven from the command registers.
  - Write goes to DONE.
  - Read loads the wait counter with MEM_LAT and goes to WAIT.
- WAIT:
  - Decrement the counter each cycle.
  - On the last WAIT cycle (counter=1), capture mem_rdata into the owner's rdata register, then go to DONE.
  - WAIT lasts exactly MEM_LAT cycles.
- DONE:
  - Pulse cpu_ready (owner=0) or dma_ack (owner=1) high for one cycle, then go to IDLE.
  - Requests are ignored in DONE.
- mem_en=0 in every state except ISSUE. mem_addr/mem_wdata hold their last values when mem_en=0.
- Latency, with the request sampled at the end of IDLE cycle T:
  - Write: ack in cycle T+2.
  - Read: ack in cycle T+2+MEM_LAT, with rdata valid in that same cycle.
- Requester rules:
  - A requester must deassert req (or present a new command) in the cycle after its ack.
  - A req still high in the following IDLE cycle is a new transaction.
  - Request inputs are don't-care after latching; changing them mid-transaction has no effect.
- rdata registers:
  - Each rdata updates only on that requester's reads and holds its value otherwise, including across writes and the other requester's accesses.
- Arbitration in IDLE:
  - Only one req high: that requester wins.
  - Both high: CPU wins, unless starve_cnt == STARVE_LIMIT, in which case DMA wins.
- starve_cnt:
  - Increments on each CPU grant made while dma_req=1.
  - Clears on any DMA grant, and on any CPU grant made while dma_req=0.
  - Saturates at STARVE_LIMIT.
- Back-to-back throughput: one access per 3 cycles for writes, 3+MEM_LAT cycles for reads; there are no idle bubbles beyond the IDLE cycle.

Test Plan:
- Reset, then release; reset asserted again during WAIT of a CPU read → all outputs 0 immediately, no cpu_ready, FSM in IDLE after release.
- CPU write addr=0x10, wdata=0xDEADBEEF, MEM_LAT=1 → mem_en=1/mem_we=1 with those values in cycle T+1; cpu_ready pulse in T+2; dma_ack stays 0.
- CPU read addr=0x10, memory returning 0xDEADBEEF, MEM_LAT=1 and MEM_LAT=3 → cpu_ready at T+3 and T+5 respectively; cpu_rdata=0xDEADBEEF at the pulse; dma_rdata unchanged.
- cpu_req and dma_req both held continuously, STARVE_LIMIT=4 → grant sequence C,C,C,C,D,C,C,C,C,D; owner follows it; no two acks are ever high together.
- DMA loader writes words 0..7 to addresses 0x0..0x1C, then the CPU reads 0x8 → cpu_rdata=2; dma_rdata stays 0, since the DMA made no reads.
- Requester holds req high for one extra cycle after its ack → exactly one additional transaction is issued; changing cpu_addr during WAIT does not change mem_addr.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one unified memory between the CPU and a DMA/loader port.
// Each access runs IDLE -> ISSUE -> (WAIT x MEM_LAT for reads) -> DONE.
module mem_port_arbiter #(
  parameter int unsigned AW           = 32,
  parameter int unsigned DW           = 32,
  parameter int unsigned MEM_LAT      = 1,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_ready,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  output logic [DW-1:0] dma_rdata,
  output logic          dma_ack,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic          owner
);

  localparam int unsigned CntW = $clog2(MEM_LAT + 1);
  localparam int unsigned StW  = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [CntW-1:0] LatInit = CntW'(MEM_LAT);
  localparam logic [StW-1:0]  StLimit = StW'(STARVE_LIMIT);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

  state_e          state_q, state_d;
  logic            owner_q, owner_d;
  logic            we_q, we_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [DW-1:0]   cpu_rdata_q, cpu_rdata_d;
  logic [DW-1:0]   dma_rdata_q, dma_rdata_d;
  logic [CntW-1:0] wait_q, wait_d;
  logic [StW-1:0]  starve_q, starve_d;
  logic            any_req;
  logic            grant_dma;

  assign any_req   = cpu_req | dma_req;
  // CPU has priority unless the DMA has been passed over STARVE_LIMIT times in a row.
  assign grant_dma = dma_req & (~cpu_req | (starve_q == StLimit));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (any_req) state_d = StIssue;
      StIssue: state_d = we_q ? StDone : StWait;
      StWait:  if (wait_q == CntW'(1)) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    owner_d     = owner_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cpu_rdata_d = cpu_rdata_q;
    dma_rdata_d = dma_rdata_q;
    wait_d      = wait_q;
    starve_d    = starve_q;
    if (state_q == StIdle && any_req) begin
      owner_d = grant_dma;
      we_d    = grant_dma ? dma_we    : cpu_we;
      addr_d  = grant_dma ? dma_addr  : cpu_addr;
      wdata_d = grant_dma ? dma_wdata : cpu_wdata;
      if (grant_dma || !dma_req) begin
        starve_d = '0;
      end else if (starve_q != StLimit) begin
        starve_d = starve_q + 1'b1;
      end
    end
    if (state_q == StIssue && !we_q) begin
      wait_d = LatInit;
    end
    if (state_q == StWait) begin
      wait_d = wait_q - 1'b1;
      if (wait_q == CntW'(1)) begin
        if (owner_q) begin
          dma_rdata_d = mem_rdata;
        end else begin
          cpu_rdata_d = mem_rdata;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner_q     <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
      wait_q      <= '0;
      starve_q    <= '0;
    end else begin
      owner_q     <= owner_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      dma_rdata_q <= dma_rdata_d;
      wait_q      <= wait_d;
      starve_q    <= starve_d;
    end
  end

  always_comb begin
    mem_en    = (state_q == StIssue);
    mem_we    = (state_q == StIssue) & we_q;
    cpu_ready = (state_q == StDone) & ~owner_q;
    dma_ack   = (state_q == StDone) & owner_q;
    busy      = (state_q != StIdle);
  end

  // Command registers drive the memory bus directly, so it holds between accesses.
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign cpu_rdata = cpu_rdata_q;
  assign dma_rdata = dma_rdata_q;
  assign owner     = owner_q;

endmodule
